// File: rtl/adder_pkg.sv
// adder_pkg: default geometry for pipelined_adder and the chunk-width derivation.
package adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 4;
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result valid-ready bundle; Ovf exists only with PIPELINED_ADDER_OVF_EN.
interface pipelined_adder_if import adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic in_valid, in_ready, Cin, out_valid, out_ready, Cout;
  logic [WIDTH-1:0] A, B, Sum;
`ifdef PIPELINED_ADDER_OVF_EN
  logic Ovf;
  modport master (output in_valid, A, B, Cin, out_ready, input in_ready, out_valid, Sum, Cout, Ovf);
  modport slave (input in_valid, A, B, Cin, out_ready, output in_ready, out_valid, Sum, Cout, Ovf);
`else
  modport master (output in_valid, A, B, Cin, out_ready, input in_ready, out_valid, Sum, Cout);
  modport slave (input in_valid, A, B, Cin, out_ready, output in_ready, out_valid, Sum, Cout);
`endif
endinterface

// File: rtl/adder_stage.sv
// adder_stage: one CHUNK-bit slice of the adder with registered sum, carry and valid.
module adder_stage #(
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             prev_valid,
  input  logic             prev_carry,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] sum,
  output logic             carry,
  output logic             valid
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      carry <= 1'b0;
      valid <= 1'b0;
    end else if (en) begin
      {carry, sum} <= {1'b0, a} + {1'b0, b} + (CHUNK + 1)'(prev_carry);
      valid <= prev_valid;
    end
  end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked adder with operand skew, result de-skew and valid/ready flow control.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output Ovf.
module pipelined_adder import adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic clk,
  input logic rst,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  logic en;
  logic [STAGES:0] cc, vv;
  logic [WIDTH-1:0] a_sk, b_sk, s_raw, sum;
  assign en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign cc[0] = bus.Cin;
  assign vv[0] = bus.in_valid;
  assign bus.out_valid = vv[STAGES];
  assign bus.Cout = cc[STAGES];
  assign bus.Sum = sum;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(.CHUNK(CHUNK)) u_stage (
      .clk(clk), .rst(rst), .en(en),
      .prev_valid(vv[k]), .prev_carry(cc[k]),
      .a(a_sk[k*CHUNK +: CHUNK]), .b(b_sk[k*CHUNK +: CHUNK]),
      .sum(s_raw[k*CHUNK +: CHUNK]), .carry(cc[k+1]), .valid(vv[k+1])
    );
    // chunk k waits k cycles so it meets the carry produced for its transaction
    if (k == 0) begin : g_direct
      assign a_sk[CHUNK-1:0] = bus.A[CHUNK-1:0];
      assign b_sk[CHUNK-1:0] = bus.B[CHUNK-1:0];
    end else begin : g_skew
      logic [CHUNK-1:0] ad [1:k];
      logic [CHUNK-1:0] bd [1:k];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 1; d <= k; d++) begin
            ad[d] <= '0;
            bd[d] <= '0;
          end
        end else if (en) begin
          ad[1] <= bus.A[k*CHUNK +: CHUNK];
          bd[1] <= bus.B[k*CHUNK +: CHUNK];
          for (int d = 2; d <= k; d++) begin
            ad[d] <= ad[d-1];
            bd[d] <= bd[d-1];
          end
        end
      end
      assign a_sk[k*CHUNK +: CHUNK] = ad[k];
      assign b_sk[k*CHUNK +: CHUNK] = bd[k];
    end
    // finished chunk k waits for the top chunk so the whole result lands together
    if (k == STAGES - 1) begin : g_last
      assign sum[k*CHUNK +: CHUNK] = s_raw[k*CHUNK +: CHUNK];
    end else begin : g_deskew
      logic [CHUNK-1:0] sd [1:STAGES-1-k];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 1; d <= STAGES - 1 - k; d++) sd[d] <= '0;
        end else if (en) begin
          sd[1] <= s_raw[k*CHUNK +: CHUNK];
          for (int d = 2; d <= STAGES - 1 - k; d++) sd[d] <= sd[d-1];
        end
      end
      assign sum[k*CHUNK +: CHUNK] = sd[STAGES-1-k];
    end
  end
`ifdef PIPELINED_ADDER_OVF_EN
  logic msb_x;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) msb_x <= 1'b0;
    else if (en) msb_x <= a_sk[WIDTH-1] ^ b_sk[WIDTH-1];
  end
  // carry into the MSB is a^b^sum at that bit; overflow is that XOR carry out
  assign bus.Ovf = msb_x ^ s_raw[WIDTH-1] ^ cc[STAGES];
`endif
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, meaning the number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the operands are presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the operands this cycle.
REQ-007 The block SHALL have ports A and B, input, WIDTH, unsigned operands.
REQ-008 The block SHALL have port Cin, input, 1, carry in.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-011 The block SHALL have ports Sum (output, WIDTH) and Cout (output, 1), the result and carry out.

Function
REQ-012 The block SHALL split operands into STAGES chunks of CHUNK = WIDTH/STAGES bits; stage k adds chunk k (LSB chunk first) plus the registered carry from stage k-1, with Cin feeding stage 0.
REQ-013 Unconsumed operand chunks SHALL be skew-delayed and completed sum chunks de-skewed, so Sum/Cout for one transaction appear together.
REQ-014 {Cout,Sum} SHALL equal A + B + Cin exactly (WIDTH+1 bits, no truncation).
REQ-015 Pipeline advance enable SHALL be (!out_valid || out_ready); in_ready SHALL equal that enable, combinationally.
REQ-016 A transfer SHALL occur on a cycle with in_valid && in_ready; a transaction SHALL reach out_valid exactly STAGES cycles after its transfer when never stalled.
REQ-017 Throughput SHALL be one transaction per cycle with out_ready held high; back-to-back results SHALL keep input order.
REQ-018 While out_valid && !out_ready, all pipeline registers SHALL hold; Sum, Cout and out_valid SHALL remain stable.
REQ-019 Cycles with in_valid low during advance SHALL insert bubbles (valid bit 0) that propagate; bubbles SHALL NOT raise out_valid.
REQ-020 Operands presented while in_ready is low SHALL NOT be captured.
REQ-021 Carry propagation from chunk STAGES-1 SHALL drive Cout; an all-ones + all-ones + Cin=1 sum SHALL not lose a carry across any chunk boundary.

Reset
REQ-022 Assertion of rst SHALL immediately clear every stage valid bit, out_valid, Sum, Cout and all carry registers to 0, independent of clk.
REQ-023 Reset mid-operation SHALL discard all in-flight transactions; none SHALL emerge after release.
REQ-024 in_ready SHALL be 1 during and after reset (pipeline empty).

Configuration
REQ-025 With macro PIPELINED_ADDER_OVF_EN defined, the block SHALL add output port Ovf, 1 bit, equal to signed overflow (carry into MSB XOR Cout), aligned and held with Sum, reset to 0.
REQ-026 Without PIPELINED_ADDER_OVF_EN, port Ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package adder_pkg SHALL hold default WIDTH and STAGES constants and the CHUNK derivation function.
REQ-028 One sub-module, adder_stage, SHALL implement a CHUNK-bit add with registered sum chunk, carry and valid, instantiated STAGES times by generate.

Verification (WIDTH=32, STAGES=4)
REQ-029 Reset then A=0x0000_0001, B=0x0000_0002, Cin=0, out_ready=1 -> out_valid after 4 cycles, Sum=0x0000_0003, Cout=0.
REQ-030 A=0xFFFF_FFFF, B=0x0000_0000, Cin=1 -> Sum=0x0000_0000, Cout=1 (carry through all chunks); with OVF_EN, Ovf=0.
REQ-031 A=0x7FFF_FFFF, B=0x0000_0001, Cin=0 with OVF_EN -> Sum=0x8000_0000, Cout=0, Ovf=1.
REQ-032 Stream 8 random transactions, out_ready=0 for cycles 6-9 -> in_ready=0 and outputs frozen in that window; all 8 results correct, in order, none lost or duplicated.
REQ-033 Assert rst with 3 transactions in flight -> out_valid=0 immediately; no result emerges in the 10 cycles after release.
REQ-034 Alternate in_valid 1/0 for 6 cycles with out_ready=1 -> out_valid pattern 1/0 delayed 4 cycles, values correct.
